// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the muxed-gate response checker: FSM encoding,
// gate-select codes and code-space constants.
package gate_response_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_XOR  = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;
  localparam logic [2:0] GATE_NOTA = 3'd6;
  localparam logic [2:0] GATE_BUF  = 3'd7;

  localparam int NUM_CODES = 32;
  localparam int CODE_W    = 5;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/gate_response_checker_golden.sv
// Golden 8-gate truth table: maps a 5-bit {sel, b, a} code to the LED value
// a correct muxed-gate DUT must produce.
module gate_golden_model
  import gate_response_checker_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              expected
);

  logic [2:0] sel_s;
  logic       a_s;
  logic       b_s;

  assign sel_s = code[4:2];
  assign b_s   = code[1];
  assign a_s   = code[0];

  // Gate selection
  always_comb begin
    expected = 1'b0;
    case (sel_s)
      GATE_AND:  expected = a_s & b_s;
      GATE_OR:   expected = a_s | b_s;
      GATE_XOR:  expected = a_s ^ b_s;
      GATE_NAND: expected = ~(a_s & b_s);
      GATE_NOR:  expected = ~(a_s | b_s);
      GATE_XNOR: expected = ~(a_s ^ b_s);
      GATE_NOTA: expected = ~a_s;
      GATE_BUF:  expected = a_s;
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Observing end of the muxed-gate test path: latches each swept code, waits for
// the DUT to settle, compares its LED against the golden table and keeps a record.
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sample_valid,
  input  logic [CODE_W-1:0]    sw_obs,
  input  logic                 led_obs,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 first_fail_valid,
  output logic [CODE_W-1:0]    first_fail_code,
  output logic [NUM_CODES-1:0] seen_map,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  state_t               state_r, state_s;
  logic [CODE_W-1:0]    code_r, code_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [ERR_W-1:0]     err_r, err_s;
  logic                 ffv_r, ffv_s;
  logic [CODE_W-1:0]    ffc_r, ffc_s;
  logic [NUM_CODES-1:0] seen_r, seen_s;
  logic                 ovr_r, ovr_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 pass_r, pass_s;
  logic                 expected_s;

  gate_golden_model u_golden (
    .code     (code_r),
    .expected (expected_s)
  );

  // Next-state and next-record computation
  always_comb begin
    state_s = state_r;
    code_s  = code_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    ffv_s   = ffv_r;
    ffc_s   = ffc_r;
    seen_s  = seen_r;
    ovr_s   = ovr_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // start takes priority over a coincident sample_valid
        if (start) begin
          err_s   = '0;
          ffv_s   = 1'b0;
          ffc_s   = '0;
          seen_s  = '0;
          ovr_s   = 1'b0;
          state_s = ST_ARM;
        end else begin
          state_s = state_r;
        end
      end
      ST_ARM: begin
        if (sample_valid) begin
          code_s  = sw_obs;
          cnt_s   = SETTLE_LOAD;
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_SETTLE: begin
        ovr_s = ovr_r | sample_valid;
        if (cnt_r <= 4'd1) begin
          cnt_s   = '0;
          state_s = ST_COMPARE;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_COMPARE: begin
        ovr_s  = ovr_r | sample_valid;
        seen_s = seen_r | (32'd1 << code_r);
        if (led_obs != expected_s) begin
          err_s = (err_r == ERR_MAX) ? ERR_MAX : err_r + ERR_ONE;
          if (!ffv_r) begin
            ffv_s = 1'b1;
            ffc_s = code_r;
          end else begin
            ffc_s = ffc_r;
          end
        end else begin
          err_s = err_r;
        end
        if (&seen_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ARM;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s == ST_ARM) || (state_s == ST_SETTLE) || (state_s == ST_COMPARE);
    done_s = (state_s == ST_DONE);
    pass_s = (state_s == ST_DONE) && (err_s == '0);
  end

  // State and record registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      code_r  <= '0;
      cnt_r   <= '0;
      err_r   <= '0;
      ffv_r   <= 1'b0;
      ffc_r   <= '0;
      seen_r  <= '0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      code_r  <= code_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      ffv_r   <= ffv_s;
      ffc_r   <= ffc_s;
      seen_r  <= seen_s;
      ovr_r   <= ovr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_code  = ffc_r;
  assign seen_map         = seen_r;
  assign overrun          = ovr_r;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: a transaction-level reference model
// checked every cycle against two instances (ERR_W=6 and ERR_W=2), plus literal pins.
module tb_gate_response_checker;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [4:0]  sw_obs = 5'd0;
  logic        led_obs = 1'b0;

  logic        busy, done, pass, ffv, overrun;
  logic [5:0]  err_count;
  logic [4:0]  ffc;
  logic [31:0] seen_map;

  logic        s_busy, s_done, s_pass, s_ffv, s_overrun;
  logic [1:0]  s_err;
  logic [4:0]  s_ffc;
  logic [31:0] s_seen;

  int tests = 0;
  int fails = 0;

  // Fault injection for the emulated gate DUT: 0 ideal, 1 invert one code, 2 stuck0, 3 stuck1
  int         fault_mode = 0;
  logic [4:0] fault_code = 5'd0;

  // Reference model state
  bit          m_active, m_done, m_ovr, m_ffv;
  int          m_err, m_rem;
  logic [4:0]  m_code, m_ffc;
  logic [31:0] m_seen;

  always #5 clk = ~clk;

  gate_response_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .sw_obs(sw_obs), .led_obs(led_obs), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_valid(ffv), .first_fail_code(ffc),
    .seen_map(seen_map), .overrun(overrun)
  );

  gate_response_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .sw_obs(sw_obs), .led_obs(led_obs), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_fail_valid(s_ffv), .first_fail_code(s_ffc),
    .seen_map(s_seen), .overrun(s_overrun)
  );

  // Truth table packed by code index: nibble per gate select, bit = {b,a}
  function automatic logic golden_bit(input logic [4:0] c);
    logic [31:0] tt;
    tt = 32'hA59176E8;
    return tt[c];
  endfunction

  function automatic logic led_for(input logic [4:0] c);
    case (fault_mode)
      1:       return (c == fault_code) ? ~golden_bit(c) : golden_bit(c);
      2:       return 1'b0;
      3:       return 1'b1;
      default: return golden_bit(c);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: sample accepted when sweep active and nothing pending; result lands S+1 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_ovr <= 1'b0; m_ffv <= 1'b0;
      m_err <= 0; m_rem <= 0; m_code <= 5'd0; m_ffc <= 5'd0; m_seen <= 32'd0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1; m_done <= 1'b0; m_ovr <= 1'b0; m_ffv <= 1'b0;
        m_err <= 0; m_ffc <= 5'd0; m_seen <= 32'd0; m_rem <= 0;
      end
    end else if (m_rem > 0) begin
      if (sample_valid) m_ovr <= 1'b1;
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_seen[m_code] <= 1'b1;
        if (led_obs !== golden_bit(m_code)) begin
          m_err <= m_err + 1;
          if (!m_ffv) begin
            m_ffv <= 1'b1;
            m_ffc <= m_code;
          end
        end
        if ((m_seen | (32'd1 << m_code)) == 32'hFFFFFFFF) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end else if (sample_valid) begin
      m_code <= sw_obs;
      m_rem  <= SETTLE + 1;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    int e6, e2;
    e6 = (m_err > 63) ? 63 : m_err;
    e2 = (m_err > 3) ? 3 : m_err;
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("pass", {31'd0, pass}, {31'd0, (m_done && m_err == 0)});
    chk("err_count", {26'd0, err_count}, e6);
    chk("first_fail_valid", {31'd0, ffv}, {31'd0, m_ffv});
    chk("first_fail_code", {27'd0, ffc}, {27'd0, m_ffc});
    chk("seen_map", seen_map, m_seen);
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("small_err_count", {30'd0, s_err}, e2);
    chk("small_pass", {31'd0, s_pass}, {31'd0, (m_done && m_err == 0)});
    chk("small_done", {31'd0, s_done}, {31'd0, m_done});
    chk("small_seen_map", s_seen, m_seen);
  end

  task automatic pulse_start(input logic with_sample);
    @(negedge clk);
    start = 1'b1;
    sample_valid = with_sample;
    @(negedge clk);
    start = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] c);
    @(negedge clk);
    sw_obs = c;
    led_obs = led_for(c);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (SETTLE + 1) @(negedge clk);
  endtask

  task automatic sweep();
    for (int c = 0; c < 32; c++) send(5'(c));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk);
    #2 rst_n = v;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {26'd0, err_count}, 32'd0);
    chk("reset_seen", seen_map, 32'd0);
    set_rst(1'b1);

    // 1: ideal DUT, full sweep, with an ignored start mid-sweep
    fault_mode = 0;
    pulse_start(1'b0);
    for (int c = 0; c < 32; c++) begin
      send(5'(c));
      if (c == 10) pulse_start(1'b0);
    end
    wait_done();
    chk("t1_pass", {31'd0, pass}, 32'd1);
    chk("t1_err", {26'd0, err_count}, 32'd0);
    chk("t1_seen", seen_map, 32'hFFFFFFFF);

    // 2: one inverted code; start restarts from DONE and wins over sample_valid
    fault_mode = 1; fault_code = 5'h0A;
    pulse_start(1'b1);
    chk("t2_cleared_seen", seen_map, 32'd0);
    sweep();
    wait_done();
    chk("t2_err", {26'd0, err_count}, 32'd1);
    chk("t2_ffc", {27'd0, ffc}, 32'h0A);
    chk("t2_pass", {31'd0, pass}, 32'd0);

    // 3: stuck-at-0 LED
    fault_mode = 2;
    pulse_start(1'b0);
    sweep();
    wait_done();
    chk("t3_err", {26'd0, err_count}, 32'd16);
    chk("t3_ffc", {27'd0, ffc}, 32'h03);
    chk("t3_small_err", {30'd0, s_err}, 32'd3);

    // 4: back-to-back sample is an overrun and is dropped
    fault_mode = 0;
    pulse_start(1'b0);
    @(negedge clk);
    sw_obs = 5'h04; led_obs = led_for(5'h04); sample_valid = 1'b1;
    @(negedge clk);
    sw_obs = 5'h11; led_obs = led_for(5'h11); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    chk("t4_seen", seen_map, 32'h00000010);
    set_rst(1'b0);
    set_rst(1'b1);

    // 5: repeated code does not complete the sweep; last code does; reset mid-sweep
    pulse_start(1'b0);
    for (int c = 0; c < 31; c++) send(5'(c));
    send(5'd3);
    chk("t5_not_done", {31'd0, done}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    send(5'd31);
    wait_done();
    pulse_start(1'b0);
    send(5'd0);
    send(5'd1);
    @(negedge clk);
    sw_obs = 5'd2; led_obs = led_for(5'd2); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    set_rst(1'b0);
    @(negedge clk);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_seen", seen_map, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    set_rst(1'b1);

    // 6: stuck-at-1 saturates the narrow counter; start in DONE clears the record
    fault_mode = 3;
    pulse_start(1'b0);
    sweep();
    wait_done();
    chk("t6_small_err", {30'd0, s_err}, 32'd3);
    chk("t6_err", {26'd0, err_count}, 32'd16);
    chk("t6_small_pass", {31'd0, s_pass}, 32'd0);
    pulse_start(1'b0);
    chk("t6_clr_err", {30'd0, s_err}, 32'd0);
    chk("t6_clr_ffv", {31'd0, s_ffv}, 32'd0);
    chk("t6_clr_busy", {31'd0, s_busy}, 32'd1);
    chk("t6_clr_done", {31'd0, s_done}, 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
